oh_csa_acc: RTL and testbench

Multi-beat carry-save accumulator that sits directly downstream of the 4:2 compressor. It keeps a running sum in redundant sum/carry form. Each accepted beat adds two DW-bit operands using one oh_csa42 row, so there is no carry propagation in the accumulate loop. On the last beat it resolves the redundant pair into a binary result with a chunked, multi-cycle carry-propagate adder. Typical use is dot-product and partial-product reduction engines.

---
 rtl/oh_csa_acc_pkg.sv | 19 +
 rtl/oh_csa42.sv | 23 ++
 rtl/oh_csa_acc.sv | 173 +++++++++++++++++
 tb/tb_oh_csa_acc.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/oh_csa_acc_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package oh_csa_acc_pkg;

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
    ST_RES = 2'd1,
    ST_OUT = 2'd2
  } state_e;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 8;
  localparam int NCHUNK = DW_DEF / CW_DEF;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/oh_csa42.sv
// One row of 4:2 compressors: in0+in1+in2+in3+cin = s + 2*c + 2*cout per bit.
module oh_csa42 #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  input  logic [DW-1:0] cin,
  output logic [DW-1:0] s,
  output logic [DW-1:0] c,
  output logic [DW-1:0] cout
);

  logic [DW-1:0] t_s;

  // cout depends only on in0..in2, so chaining cout into the next cin never loops.
  assign t_s  = in0 ^ in1 ^ in2;
  assign cout = (in0 & in1) | (in0 & in2) | (in1 & in2);
  assign s    = t_s ^ in3 ^ cin;
  assign c    = (t_s & in3) | (t_s & cin) | (in3 & cin);

endmodule

// File: rtl/oh_csa_acc.sv
// Carry-save accumulator with chunked multi-cycle resolve.
// Optional overflow tracking enabled by defining OH_CSA_ACC_OVF_EN.
module oh_csa_acc
  import oh_csa_acc_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_ovf
);

  localparam int NCH = DW / CW;
  localparam int KW  = cnt_w(NCH);
  localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] acc_s_q, acc_s_d;
  logic [DW-1:0] acc_c_q, acc_c_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [DW-1:0] res_q, res_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;

  logic [DW-1:0] s_s, c_s, cout_s, cin_s;
  logic [CW-1:0] chunk_a_s, chunk_b_s;
  logic [CW:0]   sum_s;

`ifdef OH_CSA_ACC_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_out_q, ovf_out_d;
`endif

  // Ripple the row's cout into the next bit's cin; cout[DW-1] falls off the top.
  assign cin_s = cout_s << 32'd1;

  oh_csa42 #(.DW(DW)) u_row (
    .in0  (acc_s_q),
    .in1  (acc_c_q),
    .in2  (in_a),
    .in3  (in_b),
    .cin  (cin_s),
    .s    (s_s),
    .c    (c_s),
    .cout (cout_s)
  );

  assign chunk_a_s = acc_s_q[k_q*CW +: CW];
  assign chunk_b_s = acc_c_q[k_q*CW +: CW];
  assign sum_s     = {1'b0, chunk_a_s} + {1'b0, chunk_b_s} + {{CW{1'b0}}, carry_q};

  // Next-state logic for the accumulate / resolve / output sequence.
  always_comb begin
    state_d     = state_q;
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    k_d         = k_q;
    carry_d     = carry_q;
    res_d       = res_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef OH_CSA_ACC_OVF_EN
    ovf_d       = ovf_q;
    ovf_out_d   = ovf_out_q;
`endif
    case (state_q)
      ST_ACC: begin
        if (in_valid) begin
          acc_s_d = s_s;
          acc_c_d = c_s << 32'd1;
`ifdef OH_CSA_ACC_OVF_EN
          ovf_d = ovf_q | c_s[DW-1] | cout_s[DW-1];
`endif
          if (in_last) begin
            state_d    = ST_RES;
            k_d        = {KW{1'b0}};
            carry_d    = 1'b0;
            in_ready_d = 1'b0;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_RES: begin
        res_d[k_q*CW +: CW] = sum_s[CW-1:0];
        carry_d             = sum_s[CW];
        if (k_q == K_LAST) begin
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
`ifdef OH_CSA_ACC_OVF_EN
          ovf_out_d = ovf_q | sum_s[CW];
`endif
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d     = ST_ACC;
          acc_s_d     = {DW{1'b0}};
          acc_c_d     = {DW{1'b0}};
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
`ifdef OH_CSA_ACC_OVF_EN
          ovf_d = 1'b0;
`endif
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d     = ST_ACC;
        acc_s_d     = {DW{1'b0}};
        acc_c_d     = {DW{1'b0}};
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any partial transaction.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_ACC;
      acc_s_q     <= {DW{1'b0}};
      acc_c_q     <= {DW{1'b0}};
      k_q         <= {KW{1'b0}};
      carry_q     <= 1'b0;
      res_q       <= {DW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef OH_CSA_ACC_OVF_EN
      ovf_q       <= 1'b0;
      ovf_out_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_s_q     <= acc_s_d;
      acc_c_q     <= acc_c_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef OH_CSA_ACC_OVF_EN
      ovf_q       <= ovf_d;
      ovf_out_q   <= ovf_out_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = res_q;
`ifdef OH_CSA_ACC_OVF_EN
  assign out_ovf   = ovf_out_q;
`else
  assign out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_oh_csa_acc.sv
// Directed scoreboard bench for oh_csa_acc (DW=32, CW=8).
module tb_oh_csa_acc;

  localparam int DW = 32;
  localparam int CW = 8;
`ifdef OH_CSA_ACC_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nreset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_ovf;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  logic [DW:0]   sb_q[$];
  logic [63:0]   model_sum = 64'd0;
  logic [DW:0]   junk_r;

  oh_csa_acc #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat and update the reference model; push the result on last.
  task automatic beat(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic last);
    logic ovf;
    @(negedge clk);
    chk({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    model_sum = model_sum + {32'd0, a} + {32'd0, b};
    if (last) begin
      ovf = OVF_EN & (model_sum >= 64'h1_0000_0000);
      sb_q.push_back({ovf, model_sum[DW-1:0]});
      model_sum = 64'd0;
    end
    @(posedge clk);
  endtask

  // Wait for out_valid, check latency and compare against the scoreboard.
  task automatic get_result(input string tag, input int exp_lat);
    int n;
    logic [DW:0] e;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " sb_nonempty"}, {63'd0, (sb_q.size() > 0)}, 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, " out_data"}, {32'd0, out_data}, {32'd0, e[DW-1:0]});
      chk({tag, " out_ovf"}, {63'd0, out_ovf}, {63'd0, e[DW]});
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " hs out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, " hs in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int seen;
    nreset    = 1'b0;
    in_valid  = 1'($urandom_range(1, 0));
    in_last   = 1'($urandom_range(1, 0));
    in_a      = $urandom;
    in_b      = $urandom;
    out_ready = 1'($urandom_range(1, 0));
    repeat (3) @(negedge clk);
    chk("reset in_ready",  {63'd0, in_ready},  64'd1);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset out_data",  {32'd0, out_data},  64'd0);
    chk("reset out_ovf",   {63'd0, out_ovf},   64'd0);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    nreset    = 1'b1;

    // single beat
    beat("single", 32'd5, 32'd7, 1'b1);
    get_result("single", 5);
    handshake("single");

    // back-to-back beats
    beat("b2b0", 32'd1, 32'd2, 1'b0);
    beat("b2b1", 32'd3, 32'd4, 1'b0);
    beat("b2b2", 32'h0000FFFF, 32'd1, 1'b1);
    get_result("b2b", 5);
    handshake("b2b");

    // backpressure with in_valid held high in OUT
    beat("bp", 32'd9, 32'd9, 1'b1);
    get_result("bp", 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_a     = $urandom;
      in_b     = $urandom;
      chk("bp out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp in_ready",  {63'd0, in_ready},  64'd0);
      chk("bp out_data",  {32'd0, out_data},  64'd18);
    end
    handshake("bp");
    beat("after_bp", 32'd2, 32'd2, 1'b1);
    get_result("after_bp", 5);
    handshake("after_bp");

    // overflow on final carry and on dropped accumulate carries
    beat("ovf1", 32'hFFFFFFFF, 32'd1, 1'b1);
    get_result("ovf1", 5);
    handshake("ovf1");
    beat("ovf2a", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    beat("ovf2b", 32'd2, 32'd0, 1'b1);
    get_result("ovf2", 5);
    handshake("ovf2");

    // overflow flag clears for the next transaction
    beat("noovf", 32'h7FFFFFFF, 32'h80000000, 1'b1);
    get_result("noovf", 5);
    handshake("noovf");

    // reset mid-resolve
    beat("rst", 32'd100, 32'd200, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("midrst in_ready",  {63'd0, in_ready},  64'd1);
    chk("midrst out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst out_data",  {32'd0, out_data},  64'd0);
    chk("midrst out_ovf",   {63'd0, out_ovf},   64'd0);
    @(negedge clk);
    nreset = 1'b1;
    junk_r = sb_q.pop_back();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst no out_valid", 64'(seen), 64'd0);
    beat("post_rst", 32'd10, 32'd20, 1'b1);
    get_result("post_rst", 5);
    handshake("post_rst");

    chk("sb drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
